// File: rtl/offchip_byte_mem_model_pkg.sv
`default_nettype none
// ============================================================================
// Module : offchip_byte_mem_model_pkg
// Brief  : Shared constants and size-mask helper for the byte memory model.
// Rev    : 1.0 - initial release
// ============================================================================
package offchip_byte_mem_model_pkg;

    localparam int c_num_ch = 2;
    localparam int c_byte_w = 8;
    localparam int c_size_w = 4;

    // Bit mask for a write of `size` bits; any size of a full byte or more covers it all.
    function automatic logic [c_byte_w-1:0] size_mask(input logic [c_size_w-1:0] size);
        logic [c_byte_w-1:0] m;
        if (size >= c_size_w'(c_byte_w)) begin
            m = '1;
        end else begin
            m = (c_byte_w'(1) << size) - c_byte_w'(1);
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/offchip_byte_mem_model_channel_ctrl.sv
`default_nettype none
// ============================================================================
// Module : byte_mem_channel_ctrl
// Brief  : One master channel: window decode, latency counter, ready strobe,
//          read-data pipe and masked write-byte generation.
// Rev    : 1.0 - initial release
// ============================================================================
module byte_mem_channel_ctrl
    import offchip_byte_mem_model_pkg::*;
#(
    parameter int MEMSIZE     = 32,
    parameter int BASE_ADDR   = 0,
    parameter int ADDR_W      = 7,
    parameter int READ_DELAY  = 2,
    parameter int WRITE_DELAY = 1,
    parameter int IDX_W       = $clog2(MEMSIZE)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_oe,
    input  logic                i_we,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [c_byte_w-1:0] i_wdata,
    input  logic [c_size_w-1:0] i_size,
    input  logic [c_byte_w-1:0] i_mem_byte,
    output logic [IDX_W-1:0]    o_idx,
    output logic                o_hit,
    output logic                o_data_rdy,
    output logic [c_byte_w-1:0] o_rdata,
    output logic                o_wr_en,
    output logic [c_byte_w-1:0] o_wr_byte
);

    localparam int c_max_delay  = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
    localparam int c_cnt_w      = (c_max_delay > 1) ? $clog2(c_max_delay) : 1;
    localparam int c_pipe_depth = READ_DELAY - 1;
    localparam logic [c_cnt_w-1:0] c_rd_last = c_cnt_w'(READ_DELAY - 1);
    localparam logic [c_cnt_w-1:0] c_wr_last = c_cnt_w'(WRITE_DELAY - 1);

    int                  w_addr_int;
    logic                w_hit;
    logic                w_rd_req;
    logic                w_wr_req;
    logic                w_rd_done;
    logic                w_wr_done;
    logic [c_byte_w-1:0] w_mask;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_byte_w-1:0] r_pipe [c_pipe_depth];

    // Signed compare keeps a zero BASE_ADDR from degenerating into an unsigned >= 0.
    assign w_addr_int = int'(i_addr);
    assign w_hit      = (w_addr_int >= BASE_ADDR) && (w_addr_int < BASE_ADDR + MEMSIZE);
    assign w_rd_req   = w_hit & i_oe;
    assign w_wr_req   = w_hit & i_we;
    assign w_rd_done  = w_rd_req & (r_cnt == c_rd_last);
    assign w_wr_done  = w_wr_req & (r_cnt == c_wr_last);
    assign w_mask     = size_mask(i_size);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_rd_req) begin
            r_cnt <= (r_cnt < c_rd_last) ? r_cnt + 1'b1 : '0;
        end else if (w_wr_req) begin
            r_cnt <= (r_cnt < c_wr_last) ? r_cnt + 1'b1 : '0;
        end else begin
            r_cnt <= '0;
        end
    end

    // Free-running sampler; the held address makes the oldest stage the read result.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < c_pipe_depth; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_mem_byte;
            for (int i = 1; i < c_pipe_depth; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_idx      = IDX_W'(w_addr_int - BASE_ADDR);
    assign o_hit      = w_hit;
    assign o_data_rdy = ~reset & (w_rd_done | w_wr_done);
    assign o_rdata    = (~reset & w_rd_done) ? r_pipe[c_pipe_depth-1] : '0;
    assign o_wr_en    = ~reset & w_wr_req;
    assign o_wr_byte  = (i_wdata & w_mask) | (i_mem_byte & ~w_mask);

endmodule
`default_nettype wire

// File: rtl/offchip_byte_mem_model.sv
`default_nettype none
// ============================================================================
// Module : offchip_byte_mem_model
// Brief  : Two-channel byte-wide off-chip memory slave with preload/readback port.
// Rev    : 1.0 - initial release
// ============================================================================
module offchip_byte_mem_model
    import offchip_byte_mem_model_pkg::*;
#(
    parameter int MEMSIZE     = 32,
    parameter int BASE_ADDR   = 0,
    parameter int ADDR_W      = 7,
    parameter int READ_DELAY  = 2,
    parameter int WRITE_DELAY = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [c_num_ch-1:0]          Mout_oe_ram,
    input  logic [c_num_ch-1:0]          Mout_we_ram,
    input  logic [c_num_ch*ADDR_W-1:0]   Mout_addr_ram,
    input  logic [c_num_ch*c_byte_w-1:0] Mout_Wdata_ram,
    input  logic [c_num_ch*c_size_w-1:0] Mout_data_ram_size,
    output logic [c_num_ch*c_byte_w-1:0] M_Rdata_ram,
    output logic [c_num_ch-1:0]          M_DataRdy,
    input  logic                         ld_we,
    input  logic [ADDR_W-1:0]            ld_addr,
    input  logic [c_byte_w-1:0]          ld_wdata,
    output logic [c_byte_w-1:0]          ld_rdata,
    output logic                         err
);

    localparam int c_idx_w = $clog2(MEMSIZE);

    logic [c_byte_w-1:0] r_mem [MEMSIZE];
    logic [c_idx_w-1:0]  w_idx      [c_num_ch];
    logic [c_byte_w-1:0] w_mem_byte [c_num_ch];
    logic [c_byte_w-1:0] w_wr_byte  [c_num_ch];
    logic [c_num_ch-1:0] w_hit;
    logic [c_num_ch-1:0] w_wr_en;
    logic                w_busy;
    int                  w_ld_int;
    logic                w_ld_hit;
    logic [c_idx_w-1:0]  w_ld_idx;
    logic                r_err;

    generate
        for (genvar g = 0; g < c_num_ch; g++) begin : g_ch
            assign w_mem_byte[g] = w_hit[g] ? r_mem[w_idx[g]] : '0;

            byte_mem_channel_ctrl #(
                .MEMSIZE     (MEMSIZE),
                .BASE_ADDR   (BASE_ADDR),
                .ADDR_W      (ADDR_W),
                .READ_DELAY  (READ_DELAY),
                .WRITE_DELAY (WRITE_DELAY),
                .IDX_W       (c_idx_w)
            ) u_ctrl (
                .clock      (clock),
                .reset      (reset),
                .i_oe       (Mout_oe_ram[g]),
                .i_we       (Mout_we_ram[g]),
                .i_addr     (Mout_addr_ram[g*ADDR_W +: ADDR_W]),
                .i_wdata    (Mout_Wdata_ram[g*c_byte_w +: c_byte_w]),
                .i_size     (Mout_data_ram_size[g*c_size_w +: c_size_w]),
                .i_mem_byte (w_mem_byte[g]),
                .o_idx      (w_idx[g]),
                .o_hit      (w_hit[g]),
                .o_data_rdy (M_DataRdy[g]),
                .o_rdata    (M_Rdata_ram[g*c_byte_w +: c_byte_w]),
                .o_wr_en    (w_wr_en[g]),
                .o_wr_byte  (w_wr_byte[g])
            );
        end
    endgenerate

    assign w_busy   = (|Mout_oe_ram) | (|Mout_we_ram);
    assign w_ld_int = int'(ld_addr);
    assign w_ld_hit = (w_ld_int >= BASE_ADDR) && (w_ld_int < BASE_ADDR + MEMSIZE);
    assign w_ld_idx = c_idx_w'(w_ld_int - BASE_ADDR);
    assign ld_rdata = w_ld_hit ? r_mem[w_ld_idx] : '0;

    // Backing store is never reset; later channels overwrite earlier ones on a shared byte.
    always_ff @(posedge clock) begin
        if (ld_we && w_ld_hit && !w_busy) begin
            r_mem[w_ld_idx] <= ld_wdata;
        end
        for (int c = 0; c < c_num_ch; c++) begin
            if (w_wr_en[c]) begin
                r_mem[w_idx[c]] <= w_wr_byte[c];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if ((|(Mout_oe_ram & Mout_we_ram)) || (ld_we && w_busy)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

endmodule
`default_nettype wire
